q2a03_clk_int_seq: RTL and testbench

Q2A03_CLK_INT_SEQ -- requirements
Module: q2a03_clk_int_seq

---
 rtl/q2a03_pkg.sv | 31 +++
 rtl/q2a03_irq_prio.sv | 28 ++
 rtl/q2a03_clk_int_seq.sv | 162 ++++++++++++++++
 tb/tb_q2a03_clk_int_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/q2a03_pkg.sv
// Shared constants and types for the 2A03-style clock, reset and interrupt sequencer.
package q2a03_pkg;

  // Master clocks per CPU cycle for the two supported video standards.
  localparam int DIV_NTSC = 12;
  localparam int DIV_PAL  = 16;

  // Processor status (P) flag bit positions.
  localparam int P_C_BIT = 0;
  localparam int P_Z_BIT = 1;
  localparam int P_I_BIT = 2;
  localparam int P_D_BIT = 3;
  localparam int P_B_BIT = 4;
  localparam int P_U_BIT = 5;
  localparam int P_V_BIT = 6;
  localparam int P_N_BIT = 7;

  // Processor status (P) flag masks.
  localparam logic [7:0] P_C_MASK = 8'h01;
  localparam logic [7:0] P_Z_MASK = 8'h02;
  localparam logic [7:0] P_I_MASK = 8'h04;
  localparam logic [7:0] P_D_MASK = 8'h08;
  localparam logic [7:0] P_B_MASK = 8'h10;
  localparam logic [7:0] P_U_MASK = 8'h20;
  localparam logic [7:0] P_V_MASK = 8'h40;
  localparam logic [7:0] P_N_MASK = 8'h80;

  // Completed CPU cycle counter.
  typedef logic [31:0] cycle_count_t;

endpackage

// File: rtl/q2a03_irq_prio.sv
// Fixed-priority IRQ selector: lowest-numbered active, unmasked source wins.
module q2a03_irq_prio
  import q2a03_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic [NUM_IRQ-1:0] mask,
  output logic               any_active,
  output logic [2:0]         id
);

  logic [NUM_IRQ-1:0] active;

  assign active = ~irq_n & ~mask;

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    any_active = |active;
    id         = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        id = 3'(i);
      end
    end
  end

endmodule

// File: rtl/q2a03_clk_int_seq.sv
// CPU clock phase generator, RDY stall, reset sequence and NMI/IRQ latching
// for a 2A03-style core. All outputs are flops aligned with the current tick.
module q2a03_clk_int_seq
  import q2a03_pkg::*;
#(
  parameter int DIV_RATIO    = 12,
  parameter int PHI2_START   = 6,
  parameter int NUM_IRQ      = 4,
  parameter int RESET_CYCLES = 7
) (
  input  logic               G_clock,
  input  logic               G_reset,
  input  logic               G_ready,
  input  logic               G_rdwr,
  input  logic               G_nmi,
  input  logic [NUM_IRQ-1:0] G_irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_enable,
  input  logic               nmi_ack,
  output logic               G_phy2,
  output logic               G_phy1,
  output logic               edge_rise,
  output logic               cycle_en,
  output logic               stall,
  output logic               reset_seq,
  output logic               nmi_pending,
  output logic               irq_pending,
  output logic [2:0]         irq_id,
  output logic [31:0]        cycle_count
);

  localparam int TICK_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_RATIO - 1);
  localparam logic [TICK_W-1:0] TICK_EDGE = TICK_W'(PHI2_START - 1);
  localparam logic [TICK_W-1:0] TICK_PHI2 = TICK_W'(PHI2_START);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              phy2_q, phy2_d;
  logic              edge_rise_q, edge_rise_d;
  logic              cycle_en_q, cycle_en_d;
  logic              stall_q, stall_d;
  logic              reset_seq_q, reset_seq_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              nmi_smp_q, nmi_smp_d;
  logic              nmi_pending_q, nmi_pending_d;
  logic              irq_pending_q, irq_pending_d;
  logic [2:0]        irq_id_q, irq_id_d;
  cycle_count_t      cycle_count_q, cycle_count_d;

  logic              nmi_fall;
  logic              prio_active;
  logic [2:0]        prio_id;

  q2a03_irq_prio #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_prio (
    .irq_n      (G_irq),
    .mask       (irq_mask),
    .any_active (prio_active),
    .id         (prio_id)
  );

  // Next-state logic. Phase outputs are decoded from tick_d so that the
  // registered versions line up exactly with tick_q.
  always_comb begin
    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);

    phy2_d      = (tick_d >= TICK_PHI2);
    edge_rise_d = (tick_d == TICK_EDGE);

    // RDY only freezes reads; the decision holds until the next phi2 rise.
    stall_d = stall_q;
    if (edge_rise_q) begin
      stall_d = ~G_ready & G_rdwr;
    end

    cycle_en_d = (tick_d == TICK_LAST) & ~stall_d;

    cycle_count_d = cycle_count_q;
    if (cycle_en_q) begin
      cycle_count_d = cycle_count_q + cycle_count_t'(1);
    end

    reset_seq_d = reset_seq_q;
    rst_cnt_d   = rst_cnt_q;
    if (reset_seq_q && cycle_en_q) begin
      if (rst_cnt_q == RST_LAST) begin
        reset_seq_d = 1'b0;
      end else begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
    end

    nmi_smp_d = nmi_smp_q;
    nmi_fall  = 1'b0;
    if (edge_rise_q) begin
      nmi_smp_d = G_nmi;
      nmi_fall  = nmi_smp_q & ~G_nmi;
    end
    // A fresh falling edge wins over an acknowledge in the same clock.
    nmi_pending_d = nmi_fall | (nmi_pending_q & ~(cycle_en_q & nmi_ack));

    irq_pending_d = irq_pending_q;
    irq_id_d      = irq_id_q;
    if (edge_rise_q) begin
      irq_pending_d = irq_enable & prio_active;
      irq_id_d      = prio_id;
    end

    // Interrupts are suppressed for as long as the reset sequence runs.
    if (reset_seq_d) begin
      nmi_pending_d = 1'b0;
      irq_pending_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset aborts any cycle in flight.
  always_ff @(posedge G_clock) begin
    if (G_reset) begin
      tick_q        <= '0;
      phy2_q        <= 1'b0;
      edge_rise_q   <= 1'b0;
      cycle_en_q    <= 1'b0;
      stall_q       <= 1'b0;
      reset_seq_q   <= 1'b1;
      rst_cnt_q     <= '0;
      nmi_smp_q     <= 1'b1;
      nmi_pending_q <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_id_q      <= 3'd0;
      cycle_count_q <= '0;
    end else begin
      tick_q        <= tick_d;
      phy2_q        <= phy2_d;
      edge_rise_q   <= edge_rise_d;
      cycle_en_q    <= cycle_en_d;
      stall_q       <= stall_d;
      reset_seq_q   <= reset_seq_d;
      rst_cnt_q     <= rst_cnt_d;
      nmi_smp_q     <= nmi_smp_d;
      nmi_pending_q <= nmi_pending_d;
      irq_pending_q <= irq_pending_d;
      irq_id_q      <= irq_id_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign G_phy2      = phy2_q;
  assign G_phy1      = ~phy2_q;
  assign edge_rise   = edge_rise_q;
  assign cycle_en    = cycle_en_q;
  assign stall       = stall_q;
  assign reset_seq   = reset_seq_q;
  assign nmi_pending = nmi_pending_q;
  assign irq_pending = irq_pending_q;
  assign irq_id      = irq_id_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_q2a03_clk_int_seq.sv
// Scoreboard bench for q2a03_clk_int_seq: a per-CPU-cycle reference model
// pushes expected boundary state; a monitor pops and compares at each boundary.
module tb_q2a03_clk_int_seq;

  localparam int DIV  = 12;
  localparam int PHI2 = 6;
  localparam int NIRQ = 4;
  localparam int RSTC = 7;

  logic            clk = 1'b0;
  logic            G_reset, G_ready, G_rdwr, G_nmi, irq_enable, nmi_ack;
  logic [NIRQ-1:0] G_irq, irq_mask;
  logic            G_phy2, G_phy1, edge_rise, cycle_en, stall, reset_seq;
  logic            nmi_pending, irq_pending;
  logic [2:0]      irq_id;
  logic [31:0]     cycle_count;

  always #5 clk = ~clk;

  q2a03_clk_int_seq #(
    .DIV_RATIO    (DIV),
    .PHI2_START   (PHI2),
    .NUM_IRQ      (NIRQ),
    .RESET_CYCLES (RSTC)
  ) dut (
    .G_clock     (clk),
    .G_reset     (G_reset),
    .G_ready     (G_ready),
    .G_rdwr      (G_rdwr),
    .G_nmi       (G_nmi),
    .G_irq       (G_irq),
    .irq_mask    (irq_mask),
    .irq_enable  (irq_enable),
    .nmi_ack     (nmi_ack),
    .G_phy2      (G_phy2),
    .G_phy1      (G_phy1),
    .edge_rise   (edge_rise),
    .cycle_en    (cycle_en),
    .stall       (stall),
    .reset_seq   (reset_seq),
    .nmi_pending (nmi_pending),
    .irq_pending (irq_pending),
    .irq_id      (irq_id),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic        ce;
    logic        stall;
    logic        rs;
    logic        nmi;
    logic        ipend;
    logic [2:0]  id;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_clk    = 0;
  bit running  = 1'b0;

  // Reference model state, advanced one CPU cycle at a time.
  bit          m_prev_nmi;
  bit          m_nmi;
  int          m_en;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_nmi = 1'b1;
    m_nmi      = 1'b0;
    m_en       = 0;
    m_count    = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_phy2"}, G_phy2, 0);
    chk({tag, "_phy1"}, G_phy1, 1);
    chk({tag, "_edge_rise"}, edge_rise, 0);
    chk({tag, "_cycle_en"}, cycle_en, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_reset_seq"}, reset_seq, 1);
    chk({tag, "_nmi_pending"}, nmi_pending, 0);
    chk({tag, "_irq_pending"}, irq_pending, 0);
    chk({tag, "_irq_id"}, irq_id, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Drive one CPU cycle's inputs (held for the whole cycle) and push the
  // state the DUT must show on that cycle's boundary tick.
  task automatic run_cycle(input bit rdy, input bit rw, input bit nmi,
                           input logic [NIRQ-1:0] irq, input logic [NIRQ-1:0] msk,
                           input bit en, input bit ack);
    exp_t            e;
    logic [NIRQ-1:0] act;
    bit              nmi_fall;
    G_ready    = rdy;
    G_rdwr     = rw;
    G_nmi      = nmi;
    G_irq      = irq;
    irq_mask   = msk;
    irq_enable = en;
    nmi_ack    = ack;

    e.rs    = (m_en < RSTC);
    e.stall = !rdy && rw;
    e.ce    = !e.stall;

    nmi_fall   = m_prev_nmi && !nmi;
    m_prev_nmi = nmi;
    if (e.rs) m_nmi = 1'b0;
    else if (nmi_fall) m_nmi = 1'b1;
    e.nmi = m_nmi;

    act  = ~irq & ~msk;
    e.id = 3'd0;
    for (int i = 0; i < NIRQ; i++) begin
      if (act[i]) begin
        e.id = 3'(i);
        break;
      end
    end
    e.ipend = !e.rs && en && (act != '0);
    e.cnt   = m_count;
    sb.push_back(e);

    if (e.ce) begin
      m_count = m_count + 32'd1;
      m_en++;
      if (ack) m_nmi = 1'b0;
    end
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (running) n_clk++;
  end

  // Monitor: phase outputs every clock, scoreboard pop on each boundary tick.
  always @(negedge clk) begin : mon
    int   t;
    exp_t e;
    if (running) begin
      t = n_clk % DIV;
      chk("phy2", G_phy2, t >= PHI2);
      chk("phy1", G_phy1, t < PHI2);
      chk("edge_rise", edge_rise, t == PHI2 - 1);
      if (t != DIV - 1) begin
        chk("cycle_en_idle", cycle_en, 0);
      end else if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: boundary at %0t with no expected entry", $time);
      end else begin
        e = sb.pop_front();
        chk("cycle_en", cycle_en, e.ce);
        chk("stall", stall, e.stall);
        chk("reset_seq", reset_seq, e.rs);
        chk("nmi_pending", nmi_pending, e.nmi);
        chk("irq_pending", irq_pending, e.ipend);
        chk("irq_id", irq_id, e.id);
        chk("cycle_count", cycle_count, e.cnt);
      end
    end
  end

  task automatic release_reset();
    G_reset = 1'b0;
    model_reset();
    n_clk   = 0;
    running = 1'b1;
  endtask

  initial begin
    G_reset    = 1'b1;
    G_ready    = 1'b1;
    G_rdwr     = 1'b1;
    G_nmi      = 1'b1;
    G_irq      = '1;
    irq_mask   = '0;
    irq_enable = 1'b0;
    nmi_ack    = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    release_reset();

    // Reset sequence plus one free cycle, never stalled.
    for (int k = 0; k < RSTC + 1; k++)
      run_cycle(1'b1, bit'($urandom_range(0, 1)), 1'b1, NIRQ'($urandom), NIRQ'($urandom),
                bit'($urandom_range(0, 1)), 1'b0);

    // RDY low on reads stalls; RDY low on writes does not.
    repeat (3) run_cycle(1'b0, 1'b1, 1'b1, '1, '0, 1'b0, 1'b0);
    repeat (2) run_cycle(1'b0, 1'b0, 1'b1, '1, '0, 1'b0, 1'b0);

    // NMI held low five cycles, acknowledged mid-way, then re-armed.
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b1);
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, '1, '0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b1);

    // IRQ priority with a masked lower source, then globally disabled.
    run_cycle(1'b1, 1'b1, 1'b1, 4'b0101, 4'b0010, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0);

    for (int k = 0; k < 60; k++)
      run_cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 2) != 0), NIRQ'($urandom), NIRQ'($urandom),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

    // Latch an NMI, start a stalled read, then reset in the middle of it.
    run_cycle(1'b1, 1'b1, 1'b1, '1, '0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, '1, '0, 1'b0, 1'b0);
    G_ready = 1'b0;
    G_rdwr  = 1'b1;
    nmi_ack = 1'b0;
    repeat (PHI2 + 2) @(posedge clk);
    #1;
    chk("mid_stall", stall, 1);
    chk("mid_nmi_pending", nmi_pending, 1);
    G_reset = 1'b1;
    running = 1'b0;
    @(posedge clk);
    #1;
    reset_checks("abort");
    @(posedge clk);
    #1;
    release_reset();
    repeat (3) run_cycle(1'b1, 1'b1, 1'b1, '1, '0, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
